fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: FIFO write data width.
REQ-003 W_CLK  input  1  write-domain clock; single clock, all logic on rising edge.
REQ-004 W_RST  input  1  reset, synchronous, active-high.
REQ-005 REQ_VALID  input  NUM_REQ  per-requester word valid.
REQ-006 REQ_DATA  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 REQ_LAST  input  NUM_REQ  per-requester last-word-of-packet flag, qualified by REQ_VALID.
REQ-008 REQ_READY  output  NUM_REQ  per-requester word accepted this cycle when high with REQ_VALID.
REQ-009 W_FULL  input  1  FIFO full flag from the write-side pointer logic.
REQ-010 W_INC  output  1  FIFO write enable.
REQ-011 W_DATA  output  DATA_WIDTH  FIFO write data.
REQ-012 GNT_ID  output  $clog2(NUM_REQ)  index of current/last grantee.
REQ-013 BUSY  output  1  high while a packet grant is held.
REQ-014 WR_CNT  output  16  total words written, wraps modulo 2^16.

Function
REQ-015 FSM has two states: IDLE and BURST.
REQ-016 IDLE: if any REQ_VALID is high, select the first requester with REQ_VALID high, searching circularly from RR_PTR; register it in GNT_ID; go to BURST next cycle. Otherwise remain in IDLE.
REQ-017 Arbitration latency is exactly one cycle; no word is transferred in IDLE.
REQ-018 BURST: REQ_READY[GNT_ID] = !W_FULL; all other REQ_READY bits are 0.
REQ-019 W_INC = (state==BURST) & REQ_VALID[GNT_ID] & !W_FULL, combinational, same cycle as the handshake.
REQ-020 W_DATA = REQ_DATA slice of GNT_ID, combinational; its value is don't-care when W_INC=0.
REQ-021 A transfer with REQ_LAST[GNT_ID]=1 returns the FSM to IDLE and sets RR_PTR = (GNT_ID+1) mod NUM_REQ.
REQ-022 Packets are atomic: the grant is held while the grantee deasserts REQ_VALID mid-packet; no other requester is served until its LAST word transfers.
REQ-023 W_FULL high in BURST stalls: W_INC=0, REQ_READY=0, state, GNT_ID and RR_PTR unchanged.
REQ-024 W_INC is never asserted while W_FULL=1 (no overflow under any input).
REQ-025 WR_CNT increments by 1 on every cycle with W_INC=1; 0xFFFF wraps to 0x0000.
REQ-026 BUSY = (state==BURST), registered.
REQ-027 A single-word packet (VALID and LAST together) occupies one arbitration cycle plus one transfer cycle.

Reset
REQ-028 While W_RST=1 at a W_CLK edge: state=IDLE, RR_PTR=0, GNT_ID=0, BUSY=0, WR_CNT=0.
REQ-029 During reset and the first cycle after it, W_INC=0 and REQ_READY=0.
REQ-030 Reset asserted mid-packet aborts the packet; no partial-packet state survives.

Structure
REQ-031 The FSM state encoding and the default NUM_REQ/DATA_WIDTH constants SHALL reside in the shared fifo_pkg.
REQ-032 The circular priority search SHALL be a combinational sub-module rr_picker (inputs: request vector, start pointer; outputs: found, index).
REQ-033 All other logic SHALL be in fifo_wr_arb; the block SHALL instantiate no FIFO storage.

Verification
REQ-034 Reset then REQ_VALID=4'b0100 with a 3-word packet 0xA1,0xA2,0xA3(LAST) -> GNT_ID=2 one cycle later; W_INC on 3 consecutive cycles with W_DATA A1,A2,A3; WR_CNT=3; BUSY low afterwards.
REQ-035 All four requesters continuously valid with 1-word packets -> grant order 0,1,2,3,0; each word takes 2 cycles.
REQ-036 W_FULL forced high for 5 cycles mid-packet -> W_INC=0 and REQ_READY=0 for those 5 cycles; the packet resumes with no lost or duplicated word.
REQ-037 Grantee 1 drops REQ_VALID for 3 cycles mid-packet while requester 3 is valid -> GNT_ID stays 1; requester 3 is served only after requester 1's LAST word transfers.
REQ-038 W_RST asserted during BURST -> next cycle IDLE, GNT_ID=0, WR_CNT=0, W_INC=0; re-arbitration starts from requester 0.
REQ-039 Preload WR_CNT to 0xFFFE via 3 writes past 0xFFFE -> WR_CNT reads 0x0001; random stimulus with a scoreboard shows W_INC&W_FULL never asserted together.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side logic: arbiter FSM encoding,
// default sizing constants and a small index helper.
package fifo_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational circular priority search: first set bit of req at or after
// start_ptr, wrapping around to bit 0.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(start_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-atomic round-robin arbiter that multiplexes several requesters onto
// a single FIFO write port and counts words written.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          W_CLK,
    input  logic                          W_RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          W_FULL,
    output logic                          W_INC,
    output logic [DATA_WIDTH-1:0]         W_DATA,
    output logic [$clog2(NUM_REQ)-1:0]    GNT_ID,
    output logic                          BUSY,
    output logic [15:0]                   WR_CNT
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (REQ_VALID),
        .start_ptr (rr_ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // Handshakes are also blocked while reset is held so a packet caught
    // mid-burst cannot push a word during the reset cycle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        REQ_READY = '0;
        W_INC     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!W_FULL && !W_RST) begin
                    REQ_READY[gnt_q] = 1'b1;
                    if (REQ_VALID[gnt_q]) begin
                        W_INC = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                        if (REQ_LAST[gnt_q]) begin
                            state_d  = ST_IDLE;
                            rr_ptr_d = IDX_W'(wrap_inc(int'(gnt_q), NUM_REQ));
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_BURST);
    end

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign W_DATA = REQ_DATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
    assign GNT_ID = gnt_q;
    assign BUSY   = busy_q;
    assign WR_CNT = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed table-driven bench for fifo_wr_arb plus hand-written sequences for
// stalls, grant holding, reset aborts, counter wrap and a random overflow sweep.
module tb_fifo_wr_arb;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic        exp_inc;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_data;
        logic [1:0]  exp_gnt;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        W_CLK;
    logic        W_RST;
    logic [3:0]  REQ_VALID;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_LAST;
    logic [3:0]  REQ_READY;
    logic        W_FULL;
    logic        W_INC;
    logic [7:0]  W_DATA;
    logic [1:0]  GNT_ID;
    logic        BUSY;
    logic [15:0] WR_CNT;

    int n_checks;
    int n_pass;

    fifo_wr_arb #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8)
    ) dut (
        .W_CLK     (W_CLK),
        .W_RST     (W_RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .W_FULL    (W_FULL),
        .W_INC     (W_INC),
        .W_DATA    (W_DATA),
        .GNT_ID    (GNT_ID),
        .BUSY      (BUSY),
        .WR_CNT    (WR_CNT)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    function automatic vec_t mk(input logic rst, input logic [3:0] valid,
                                input logic [3:0] last, input logic full,
                                input logic [31:0] data, input logic e_inc,
                                input logic [3:0] e_ready, input logic [7:0] e_data,
                                input logic [1:0] e_gnt, input logic e_busy,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.full = full; v.data = data;
        v.exp_inc = e_inc; v.exp_ready = e_ready; v.exp_data = e_data;
        v.exp_gnt = e_gnt; v.exp_busy = e_busy; v.exp_cnt = e_cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        W_RST     = v.rst;
        REQ_VALID = v.valid;
        REQ_LAST  = v.last;
        W_FULL    = v.full;
        REQ_DATA  = v.data;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        cmp(name, "w_inc", 32'(W_INC), 32'(v.exp_inc));
        cmp(name, "ready", 32'(REQ_READY), 32'(v.exp_ready));
        cmp(name, "gnt", 32'(GNT_ID), 32'(v.exp_gnt));
        cmp(name, "busy", 32'(BUSY), 32'(v.exp_busy));
        cmp(name, "wr_cnt", 32'(WR_CNT), 32'(v.exp_cnt));
        if (v.exp_inc) begin
            cmp(name, "w_data", 32'(W_DATA), 32'(v.exp_data));
        end
    endtask

    task automatic run(input vec_t v, input string name);
        applyStimulus(v);
        @(negedge W_CLK);
        checkOutput(v, name);
        @(posedge W_CLK);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(mk(1'b1, 4'b0, 4'b0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0));
        @(posedge W_CLK);
        #1;
    endtask

    vec_t tbl[18];
    int   ovf_seen;
    int   inc_seen;
    logic [15:0] cnt_start;

    initial begin
        n_checks = 0;
        n_pass   = 0;

        tbl[0]  = mk(1, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 0, 0, 16'd0);
        tbl[1]  = mk(0, 4'b0100, 4'b0000, 0, 32'h00A10000, 0, 4'b0000, 8'h00, 0, 0, 16'd0);
        tbl[2]  = mk(0, 4'b0100, 4'b0000, 0, 32'h00A10000, 1, 4'b0100, 8'hA1, 2, 1, 16'd0);
        tbl[3]  = mk(0, 4'b0100, 4'b0000, 0, 32'h00A20000, 1, 4'b0100, 8'hA2, 2, 1, 16'd1);
        tbl[4]  = mk(0, 4'b0100, 4'b0100, 0, 32'h00A30000, 1, 4'b0100, 8'hA3, 2, 1, 16'd2);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 2, 0, 16'd3);
        tbl[6]  = mk(1, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 2, 0, 16'd3);
        tbl[7]  = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 0, 4'b0000, 8'h00, 0, 0, 16'd0);
        tbl[8]  = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 1, 4'b0001, 8'h10, 0, 1, 16'd0);
        tbl[9]  = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 0, 4'b0000, 8'h00, 0, 0, 16'd1);
        tbl[10] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 1, 4'b0010, 8'h11, 1, 1, 16'd1);
        tbl[11] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 0, 4'b0000, 8'h00, 1, 0, 16'd2);
        tbl[12] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 1, 4'b0100, 8'h12, 2, 1, 16'd2);
        tbl[13] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 0, 4'b0000, 8'h00, 2, 0, 16'd3);
        tbl[14] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 1, 4'b1000, 8'h13, 3, 1, 16'd3);
        tbl[15] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 0, 4'b0000, 8'h00, 3, 0, 16'd4);
        tbl[16] = mk(0, 4'b1111, 4'b1111, 0, 32'h13121110, 1, 4'b0001, 8'h10, 0, 1, 16'd4);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 0, 0, 16'd5);

        W_RST = 1'b1; REQ_VALID = '0; REQ_LAST = '0; W_FULL = 1'b0; REQ_DATA = '0;
        repeat (2) @(posedge W_CLK);
        #1;

        for (int i = 0; i < 18; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // Five-cycle full stall in the middle of a 3-word packet from requester 1
        doReset();
        run(mk(0, 4'b0010, 4'b0000, 0, 32'h0000B100, 0, 4'b0000, 8'h00, 0, 0, 16'd0), "stall_arb");
        run(mk(0, 4'b0010, 4'b0000, 0, 32'h0000B100, 1, 4'b0010, 8'hB1, 1, 1, 16'd0), "stall_w1");
        for (int i = 0; i < 5; i++) begin
            run(mk(0, 4'b0010, 4'b0000, 1, 32'h0000B200, 0, 4'b0000, 8'h00, 1, 1, 16'd1), "stall_full");
        end
        run(mk(0, 4'b0010, 4'b0000, 0, 32'h0000B200, 1, 4'b0010, 8'hB2, 1, 1, 16'd1), "stall_w2");
        run(mk(0, 4'b0010, 4'b0010, 0, 32'h0000B300, 1, 4'b0010, 8'hB3, 1, 1, 16'd2), "stall_w3");
        run(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 1, 0, 16'd3), "stall_done");

        // Grantee 1 pauses mid-packet while requester 3 waits with LAST high
        doReset();
        run(mk(0, 4'b1010, 4'b1000, 0, 32'hD100C100, 0, 4'b0000, 8'h00, 0, 0, 16'd0), "hold_arb");
        run(mk(0, 4'b1010, 4'b1000, 0, 32'hD100C100, 1, 4'b0010, 8'hC1, 1, 1, 16'd0), "hold_w1");
        for (int i = 0; i < 3; i++) begin
            run(mk(0, 4'b1000, 4'b1000, 0, 32'hD100C200, 0, 4'b0010, 8'h00, 1, 1, 16'd1), "hold_gap");
        end
        run(mk(0, 4'b1010, 4'b1010, 0, 32'hD100C200, 1, 4'b0010, 8'hC2, 1, 1, 16'd1), "hold_last");
        run(mk(0, 4'b1000, 4'b1000, 0, 32'hD1000000, 0, 4'b0000, 8'h00, 1, 0, 16'd2), "hold_arb3");
        run(mk(0, 4'b1000, 4'b1000, 0, 32'hD1000000, 1, 4'b1000, 8'hD1, 3, 1, 16'd2), "hold_w3");
        run(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 3, 0, 16'd3), "hold_done");

        // Reset during a burst after the pointer has moved past requester 0
        doReset();
        run(mk(0, 4'b0001, 4'b0001, 0, 32'h000000E0, 0, 4'b0000, 8'h00, 0, 0, 16'd0), "rst_arb0");
        run(mk(0, 4'b0001, 4'b0001, 0, 32'h000000E0, 1, 4'b0001, 8'hE0, 0, 1, 16'd0), "rst_w0");
        run(mk(0, 4'b0100, 4'b0000, 0, 32'h00E10000, 0, 4'b0000, 8'h00, 0, 0, 16'd1), "rst_arb2");
        run(mk(0, 4'b0100, 4'b0000, 0, 32'h00E10000, 1, 4'b0100, 8'hE1, 2, 1, 16'd1), "rst_w2");
        run(mk(1, 4'b0100, 4'b0000, 0, 32'h00E20000, 0, 4'b0000, 8'h00, 2, 1, 16'd2), "rst_during");
        run(mk(0, 4'b0011, 4'b0000, 0, 32'h0000F1F0, 0, 4'b0000, 8'h00, 0, 0, 16'd0), "rst_after");
        run(mk(0, 4'b0011, 4'b0000, 0, 32'h0000F1F0, 1, 4'b0001, 8'hF0, 0, 1, 16'd0), "rst_rearb");

        // Long packet from requester 0 drives the counter up to 0xFFFE, then wraps
        doReset();
        run(mk(0, 4'b0001, 4'b0000, 0, 32'h00000055, 0, 4'b0000, 8'h00, 0, 0, 16'd0), "wrap_arb");
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(mk(0, 4'b0001, 4'b0000, 0, 32'h00000055, 0, 0, 0, 0, 0, 0));
            @(posedge W_CLK);
            #1;
        end
        run(mk(0, 4'b0001, 4'b0000, 0, 32'h00000056, 1, 4'b0001, 8'h56, 0, 1, 16'hFFFE), "wrap_a");
        run(mk(0, 4'b0001, 4'b0000, 0, 32'h00000057, 1, 4'b0001, 8'h57, 0, 1, 16'hFFFF), "wrap_b");
        run(mk(0, 4'b0001, 4'b0001, 0, 32'h00000058, 1, 4'b0001, 8'h58, 0, 1, 16'h0000), "wrap_c");
        run(mk(0, 4'b0000, 4'b0000, 0, 32'h0,        0, 4'b0000, 8'h00, 0, 0, 16'h0001), "wrap_done");

        // Random traffic: no write may coincide with full, and every write is counted
        ovf_seen = 0;
        inc_seen = 0;
        @(negedge W_CLK);
        cnt_start = WR_CNT;
        @(posedge W_CLK);
        #1;
        for (int i = 0; i < 400; i++) begin
            W_RST     = 1'b0;
            REQ_VALID = 4'($urandom_range(0, 15));
            REQ_LAST  = 4'($urandom_range(0, 15));
            W_FULL    = ($urandom_range(0, 2) == 0);
            REQ_DATA  = $urandom;
            @(negedge W_CLK);
            if (W_INC && W_FULL) ovf_seen++;
            if (W_INC) inc_seen++;
            @(posedge W_CLK);
            #1;
        end
        REQ_VALID = '0;
        W_FULL    = 1'b0;
        @(negedge W_CLK);
        cmp("rand", "overflow", 32'(ovf_seen), 32'd0);
        cmp("rand", "cnt_delta", 32'(WR_CNT - cnt_start), 32'(16'(inc_seen)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
